// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the bus widths, MIPS mul/div operation codes, FSM state
// encodings, the latched-operation context and small op-decode helpers.
package alu_muldiv_pkg;

  // Default operand / HI-LO width and operation-code width
  localparam int unsigned BUS_DAT  = 32;
  localparam int unsigned BUS_MDOP = 3;

  // Operation codes
  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MTHI  = 4;
  localparam int unsigned MD_MTLO  = 5;

  // FSM state encodings
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  // Context latched at accept and used on the final write
  typedef struct packed {
    logic is_div;  // 1: divide iteration, 0: multiply iteration
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend was negative)
  } md_ctx_t;

  // Ops that run the iterative datapath
  function automatic logic md_is_iter(input int unsigned op);
    return op <= MD_DIVU;
  endfunction

  // Ops that work on sign-magnitude operands
  function automatic logic md_is_signed(input int unsigned op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Ops that use the restoring divider
  function automatic logic md_is_div(input int unsigned op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle; MULT/MULTU use radix-2 shift-add, DIV/DIVU a
// restoring divider, both on one shared 2*B_DAT shift register.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     operation request, sampled only when not busy
//   op        operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b      rs / rt operands
//   busy      iteration in progress (pipeline stall)
//   done      one-cycle pulse, HI/LO hold the new result
//   div_zero  one-cycle pulse with done for a divide by zero
//   hi, lo    HI / LO registers
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned B_DAT  = BUS_DAT,
  parameter int unsigned B_MDOP = BUS_MDOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [B_MDOP-1:0] op,
  input  logic [B_DAT-1:0]  a,
  input  logic [B_DAT-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [B_DAT-1:0]  hi,
  output logic [B_DAT-1:0]  lo
);

  localparam int unsigned W  = B_DAT;
  localparam int unsigned CW = $clog2(B_DAT + 1);

  logic [1:0]     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2*W-1:0] acc, acc_n, acc_step;
  logic [W-1:0]   opnd, opnd_n;
  md_ctx_t        ctx, ctx_n;
  logic           busy_n, done_n, div_zero_n;
  logic [W-1:0]   hi_n, lo_n;

  // Operation decode and operand magnitudes
  logic [31:0]  op_u;
  logic         op_iter, op_signed, op_div, op_mthi, op_mtlo;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    op_u      = 32'(op);
    op_iter   = md_is_iter(op_u);
    op_signed = md_is_signed(op_u);
    op_div    = md_is_div(op_u);
    op_mthi   = (op_u == MD_MTHI);
    op_mtlo   = (op_u == MD_MTLO);
    a_mag     = (op_signed && a[W-1]) ? -a : a;
    b_mag     = (op_signed && b[W-1]) ? -b : b;
  end

  // One iteration of the shared shift register.
  // Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
  // Divide:   acc = {partial remainder, dividend / quotient bits}, opnd = divisor.
  logic [W:0] add_sum, div_trial, div_diff;

  always_comb begin
    add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : W'(0))};
    // Remainder shifted left with the next dividend bit; needs W+1 bits
    div_trial = acc[2*W-1:W-1];
    // Bit W of the difference is set exactly when trial < divisor
    div_diff  = div_trial - {1'b0, opnd};
    if (ctx.is_div) begin
      if (!div_diff[W]) begin
        acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_step = {div_trial[W-1:0], acc[W-2:0], 1'b0};
      end
    end else begin
      acc_step = {add_sum, acc[W-1:1]};
    end
  end

  // Sign correction applied on the final write
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;

  always_comb begin
    prod = ctx.neg_q ? -acc_step : acc_step;
    quo  = ctx.neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];
    rem  = ctx.neg_r ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    opnd_n     = opnd;
    ctx_n      = ctx;
    busy_n     = busy;
    done_n     = 1'b0;
    div_zero_n = 1'b0;
    hi_n       = hi;
    lo_n       = lo;

    case (state)
      MD_IDLE, MD_DONE: begin
        // DONE is a single cycle; an accept below overrides this
        state_n = MD_IDLE;
        busy_n  = 1'b0;
        if (start) begin
          if (op_iter) begin
            if (op_div && (b == W'(0))) begin
              // Divide by zero finishes immediately, HI/LO untouched
              state_n    = MD_DONE;
              done_n     = 1'b1;
              div_zero_n = 1'b1;
            end else begin
              state_n      = MD_RUN;
              busy_n       = 1'b1;
              cnt_n        = CW'(W);
              ctx_n.is_div = op_div;
              ctx_n.neg_q  = op_signed && (a[W-1] ^ b[W-1]);
              ctx_n.neg_r  = op_signed && a[W-1];
              if (op_div) begin
                acc_n  = {W'(0), a_mag};
                opnd_n = b_mag;
              end else begin
                acc_n  = {W'(0), b_mag};
                opnd_n = a_mag;
              end
            end
          end else if (op_mthi) begin
            hi_n = a;
          end else if (op_mtlo) begin
            lo_n = a;
          end
        end
      end

      MD_RUN: begin
        acc_n = acc_step;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = MD_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          if (ctx.is_div) begin
            hi_n = rem;
            lo_n = quo;
          end else begin
            hi_n = prod[2*W-1:W];
            lo_n = prod[W-1:0];
          end
        end
      end

      default: begin
        state_n = MD_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      ctx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      opnd     <= opnd_n;
      ctx      <= ctx_n;
      busy     <= busy_n;
      done     <= done_n;
      div_zero <= div_zero_n;
      hi       <= hi_n;
      lo       <= lo_n;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected HI/LO/div_zero
// results, a monitor pops and compares on every done pulse.
module tb_alu_muldiv;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_ILL   = 3'd6;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  alu_muldiv #(.B_DAT(32), .B_MDOP(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] h, input logic [31:0] l,
                          input logic dz);
    exp_t e;
    e.nm = nm; e.hi = h; e.lo = l; e.dz = dz;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.nm, "_div_zero"}, 64'(div_zero), 64'(e.dz));
      end
    end else if (!rst && div_zero) begin
      tests++;
      fails++;
      $display("FAIL div_zero_without_done: got div_zero=1 done=0, expected both or neither");
    end
  end

  // Pulse start for one accept edge; operands are scrambled afterwards
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Issue an op and wait (bounded) for done; checks latency, busy cycles, HI/LO stability
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat, input int exp_busy);
    int n, bc;
    logic moved;
    logic [31:0] h0, l0;
    issue(o, x, y);
    h0 = hi; l0 = lo; n = 0; bc = 0; moved = 1'b0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    chk({nm, "_hilo_held_in_run"}, 64'(moved), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_div_zero", 64'(div_zero), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));

    // Arithmetic, issued back-to-back in each DONE cycle
    push_exp("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32);
    push_exp("mult_m3x7", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult_m3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32, 32);
    push_exp("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32, 32);
    push_exp("divu_7d2", 32'd1, 32'd3, 1'b0);
    run_op("divu_7d2", OP_DIVU, 32'd7, 32'd2, 32, 32);
    push_exp("div_minneg", 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32, 32);
    push_exp("mult_m2xm3", 32'h00000000, 32'h00000006, 1'b0);
    run_op("mult_m2xm3", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, 32);
    push_exp("div_7dm2", 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32, 32);

    // MTHI in the DONE cycle, then MTLO; each leaves the other register alone
    issue(OP_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", 64'(hi), 64'(32'h12345678));
    chk("mthi_lo_kept", 64'(lo), 64'(32'hFFFFFFFD));
    chk("mthi_busy", 64'(busy), 64'(0));
    issue(OP_MTLO, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'(32'h9ABCDEF0));
    chk("mtlo_hi_kept", 64'(hi), 64'(32'h12345678));

    // Divide by zero: done/div_zero in the cycle after accept, no busy
    push_exp("divu_zero", 32'h12345678, 32'h9ABCDEF0, 1'b1);
    run_op("divu_zero", OP_DIVU, 32'd99, 32'd0, 0, 0);

    // Illegal op accepted in the DONE cycle: nothing happens
    issue(OP_ILL, 32'd1, 32'd1);
    chk("illegal_busy", 64'(busy), 64'(0));
    chk("illegal_hilo", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});

    // MTLO, then MULT with start re-pulsed in RUN, then reset mid-run
    issue(OP_MTLO, 32'h55, 32'h0);
    chk("mtlo55_lo", 64'(lo), 64'(32'h55));
    issue(OP_MULT, 32'd3, 32'd5);               // accept edge = cycle 0
    repeat (4) @(posedge clk);
    #1;
    issue(OP_MULT, 32'd9, 32'd9);               // sampled at cycle 5, ignored
    chk("restart_busy", 64'(busy), 64'(1));
    issue(OP_MTHI, 32'hDEAD, 32'h0);            // sampled at cycle 6, ignored
    chk("mthi_in_run_hi", 64'(hi), 64'(32'h12345678));
    chk("run_lo_held", 64'(lo), 64'(32'h55));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;                                 // sampled at cycle 10
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hilo", {hi, lo}, 64'(0));
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle_busy", 64'(busy), 64'(0));

    // Normal operation after the abort
    push_exp("multu_2p32", 32'd1, 32'd0, 1'b0);
    run_op("multu_2p32", OP_MULTU, 32'h00010000, 32'h00010000, 32, 32);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
